// File: rtl/mode_zero.sv
// mode_zero: 8254-style Mode 0 counter (interrupt on terminal count).
// A write loads the count register; the next edge transfers it into the
// counting element, which then decrements while gate0 is high. out0 rises
// when an armed count reaches zero and stays high until the next write.
module mode_zero #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count0,
    input  logic             gate0,
    input  logic             cs,
    input  logic             newCount0,
    input  logic             bcd,
    output logic             out0,
    output logic [WIDTH-1:0] count_out
);

    // Number of whole BCD digits; any leftover top bits are left untouched
    // by the BCD decrement.
    localparam int NIB = WIDTH / 4;

    logic [WIDTH-1:0] cr_reg;
    logic [WIDTH-1:0] ce_reg;
    logic             load_pending_reg;
    logic             armed_reg;
    logic             out0_reg;

    logic             wr;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] bcd_next;
    logic [WIDTH-1:0] dec_next;
    logic [NIB-1:0]   borrow;

    assign wr       = cs & newCount0;
    assign bin_next = ce_reg - WIDTH'(1);

    // The least significant digit always receives the decrement.
    assign borrow[0] = 1'b1;

    // BCD decrement: each digit borrows from the next one up when it is 0,
    // and wraps 0 -> 9. Non-BCD digit values simply decrement (no X).
    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = ce_reg[4*gi +: 4];
            assign bcd_next[4*gi +: 4] = !borrow[gi]       ? digit :
                                         (digit == 4'd0)   ? 4'd9  :
                                                             digit - 4'd1;
            if (gi < NIB - 1) begin : g_chain
                assign borrow[gi+1] = borrow[gi] & (digit == 4'd0);
            end
        end
        if (WIDTH % 4 != 0) begin : g_rem
            assign bcd_next[WIDTH-1:4*NIB] = ce_reg[WIDTH-1:4*NIB];
        end
    endgenerate

    // Format select is sampled on every count edge.
    assign dec_next = bcd ? bcd_next : bin_next;

    // Write has priority over load, load over count; terminal count is
    // detected on the 1 -> 0 decrement of an armed count only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_reg           <= '0;
            ce_reg           <= '0;
            load_pending_reg <= 1'b0;
            armed_reg        <= 1'b0;
            out0_reg         <= 1'b0;
        end else if (wr) begin
            cr_reg           <= count0;
            out0_reg         <= 1'b0;
            load_pending_reg <= 1'b1;
            armed_reg        <= 1'b0;
        end else if (load_pending_reg) begin
            ce_reg           <= cr_reg;
            load_pending_reg <= 1'b0;
            armed_reg        <= 1'b1;
        end else if (gate0) begin
            ce_reg <= dec_next;
            if (armed_reg && (ce_reg == WIDTH'(1))) begin
                out0_reg  <= 1'b1;
                armed_reg <= 1'b0;
            end
        end
    end

    assign out0      = out0_reg;
    assign count_out = ce_reg;

endmodule

// File: tb/tb_mode_zero.sv
// tb_mode_zero: directed Mode 0 scenarios. Stimulus pushes the expected
// post-edge count_out/out0 into a queue; a monitor pops and compares
// one entry after every rising edge.
module tb_mode_zero;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] count0 = '0;
    logic        gate0 = 1'b0;
    logic        cs = 1'b1;
    logic        newCount0 = 1'b0;
    logic        bcd = 1'b0;
    logic        out0;
    logic [15:0] count_out;

    int vectors = 0;
    int miscompares = 0;
    logic cs_sel = 1'b1;

    typedef struct {
        logic [15:0] ce;
        logic        o;
        string       tag;
    } exp_t;

    exp_t q[$];

    mode_zero #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count0    (count0),
        .gate0     (gate0),
        .cs        (cs),
        .newCount0 (newCount0),
        .bcd       (bcd),
        .out0      (out0),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    // Decimal 0..9999 to packed BCD.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Drive one edge worth of inputs (called at a falling edge) and queue
    // the values expected just after the following rising edge.
    task automatic step(input logic w, input logic [15:0] v, input logic g,
                        input logic [15:0] ece, input logic eo, input string tag);
        exp_t e;
        newCount0 = w;
        count0    = v;
        gate0     = g;
        cs        = cs_sel;
        e.ce  = ece;
        e.o   = eo;
        e.tag = tag;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one comparison per rising edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (count_out !== e.ce || out0 !== e.o) begin
                    miscompares++;
                    $display("FAIL %s: count_out=%h out0=%b, expected count_out=%h out0=%b",
                             e.tag, count_out, out0, e.ce, e.o);
                end else begin
                    $display("vec %0d %s: count_out=%h out0=%b ok", vectors, e.tag, count_out, out0);
                end
            end
        end
    end

    initial begin
        // Power-on reset state.
        #12;
        vectors++;
        if (count_out !== 16'h0000 || out0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_init: count_out=%h out0=%b, expected 0000/0", count_out, out0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // First edges after release are functional; no terminal count.
        step(0, 16'd0, 0, 16'h0000, 0, "idle_hold");
        step(0, 16'd0, 1, 16'hFFFF, 0, "idle_count");

        // Write 5, binary, gate high.
        step(1, 16'd5, 1, 16'hFFFF, 0, "a_write");
        for (int k = 1; k <= 5; k++) step(0, 16'd0, 1, 16'(6 - k), 0, "a_count");
        step(0, 16'd0, 1, 16'h0000, 1, "a_tc");
        step(0, 16'd0, 1, 16'hFFFF, 1, "a_wrap");
        step(0, 16'd0, 1, 16'hFFFE, 1, "a_after");

        // Write 5 with gate low for two edges.
        step(1, 16'd5, 1, 16'hFFFE, 0, "b_write");
        step(0, 16'd0, 1, 16'd5, 0, "b_load");
        step(0, 16'd0, 1, 16'd4, 0, "b_count");
        step(0, 16'd0, 1, 16'd3, 0, "b_count");
        step(0, 16'd0, 0, 16'd3, 0, "b_gate_hold");
        step(0, 16'd0, 0, 16'd3, 0, "b_gate_hold");
        step(0, 16'd0, 1, 16'd2, 0, "b_count");
        step(0, 16'd0, 1, 16'd1, 0, "b_count");
        step(0, 16'd0, 1, 16'd0, 1, "b_tc");
        step(0, 16'd0, 0, 16'd0, 1, "b_out_hold");

        // Rewrite mid-count.
        step(1, 16'd5, 1, 16'd0, 0, "c_write");
        step(0, 16'd0, 1, 16'd5, 0, "c_load");
        step(0, 16'd0, 1, 16'd4, 0, "c_count");
        step(0, 16'd0, 1, 16'd3, 0, "c_count");
        step(1, 16'd8, 1, 16'd3, 0, "c_rewrite");
        for (int k = 1; k <= 8; k++) step(0, 16'd0, 1, 16'(9 - k), 0, "c_count2");
        step(0, 16'd0, 1, 16'd0, 1, "c_tc");

        // Strobe without chip select is ignored.
        step(1, 16'd4, 1, 16'd0, 0, "d_write");
        step(0, 16'd0, 1, 16'd4, 0, "d_load");
        cs_sel = 1'b0;
        step(1, 16'd9, 1, 16'd3, 0, "d_cs_off");
        step(1, 16'd9, 1, 16'd2, 0, "d_cs_off");
        cs_sel = 1'b1;
        step(0, 16'd0, 1, 16'd1, 0, "d_count");
        step(0, 16'd0, 1, 16'd0, 1, "d_tc");

        // Held strobe re-samples; load happens with gate low.
        step(1, 16'd7, 0, 16'd0, 0, "e_write1");
        step(1, 16'd3, 0, 16'd0, 0, "e_write2");
        step(0, 16'd0, 0, 16'd3, 0, "e_load_gate_low");
        step(0, 16'd0, 0, 16'd3, 0, "e_hold");
        step(0, 16'd0, 1, 16'd2, 0, "e_count");
        step(0, 16'd0, 1, 16'd1, 0, "e_count");
        step(0, 16'd0, 1, 16'd0, 1, "e_tc");

        // BCD 0010.
        bcd = 1'b1;
        step(1, 16'h0010, 1, 16'h0000, 0, "f_write");
        step(0, 16'd0, 1, 16'h0010, 0, "f_load");
        for (int k = 2; k <= 10; k++) step(0, 16'd0, 1, to_bcd(11 - k), 0, "f_count");
        step(0, 16'd0, 1, 16'h0000, 1, "f_tc");
        step(0, 16'd0, 1, 16'h9999, 1, "f_wrap");
        step(0, 16'd0, 1, 16'h9998, 1, "f_after");

        // BCD multi-digit borrow.
        step(1, 16'h1000, 1, 16'h9998, 0, "g_write");
        step(0, 16'd0, 1, 16'h1000, 0, "g_load");
        step(0, 16'd0, 1, 16'h0999, 0, "g_borrow");
        step(0, 16'd0, 1, 16'h0998, 0, "g_count");

        // BCD count 0 means 10000.
        step(1, 16'h0000, 1, 16'h0998, 0, "h_write");
        step(0, 16'd0, 1, 16'h0000, 0, "h_load");
        for (int k = 2; k <= 10001; k++)
            step(0, 16'd0, 1, to_bcd(10001 - k), (k == 10001), "h_count");
        step(0, 16'd0, 1, 16'h9999, 1, "h_wrap");

        // Write on the terminal-count edge wins.
        bcd = 1'b0;
        step(1, 16'd2, 1, 16'h9999, 0, "i_write");
        step(0, 16'd0, 1, 16'd2, 0, "i_load");
        step(0, 16'd0, 1, 16'd1, 0, "i_count");
        step(1, 16'd6, 1, 16'd1, 0, "i_write_at_tc");
        step(0, 16'd0, 1, 16'd6, 0, "i_load");
        step(0, 16'd0, 1, 16'd5, 0, "i_count");
        step(0, 16'd0, 1, 16'd4, 0, "i_count");
        step(0, 16'd0, 1, 16'd3, 0, "i_count");

        // Asynchronous reset mid-count with CE=3.
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (count_out !== 16'h0000 || out0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: count_out=%h out0=%b, expected 0000/0", count_out, out0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) step(0, 16'd0, 1, 16'(0 - k), 0, "j_no_tc");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
